bfm_ahbmaster_lite: RTL

BFM_AHBMASTER_LITE -- requirements
Module: bfm_ahbmaster_lite

---
 rtl/bfm_ahbmaster_lite.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bfm_ahbmaster_lite.sv
// rtl/bfm_ahbmaster_lite.sv - AHB-Lite single-transfer master BFM with command/response handshake
module bfm_ahbmaster_lite #(
  parameter int          AWIDTH    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [1:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERROR,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {IDLE, DATA, ERR2} state_t;

  state_t      state, state_nxt;
  logic        a_valid;
  logic [31:0] a_wdata;
  logic        a_bad;
  logic        d_write;
  logic        d_bad;
  logic        addr_done;
  logic        data_done;
  logic        data_err;
  logic        accept;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign accept    = CMD_VALID && CMD_READY;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // HREADY/HRESP only matter while we own a data phase; a pending address
  // phase is parked as IDLE during the second error cycle.
  always_comb begin
    state_nxt = state;
    addr_done = 1'b0;
    data_done = 1'b0;
    data_err  = 1'b0;
    HTRANS    = (a_valid && state != ERR2) ? 2'b10 : 2'b00;
    case (state)
      IDLE: begin
        addr_done = a_valid;
        if (a_valid) state_nxt = DATA;
      end
      DATA: begin
        if (HREADY) begin
          data_done = 1'b1;
          data_err  = HRESP;
          addr_done = a_valid && !HRESP;
          state_nxt = (a_valid && !HRESP) ? DATA : IDLE;
        end else if (HRESP) begin
          state_nxt = ERR2;
        end
      end
      ERR2: begin
        if (HREADY) begin
          data_done = 1'b1;
          data_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    CMD_READY = !HRESET && (!a_valid || addr_done);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid   <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      a_wdata   <= 32'h0;
      a_bad     <= 1'b0;
      HWDATA    <= 32'h0;
      d_write   <= 1'b0;
      d_bad     <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERROR <= 1'b0;
      RSP_RDATA <= 32'h0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        HADDR   <= CMD_ADDR;
        HWRITE  <= CMD_WRITE;
        HSIZE   <= (CMD_SIZE == 2'd3) ? 3'b010 : {1'b0, CMD_SIZE};
        a_wdata <= CMD_WDATA;
        a_bad   <= (CMD_SIZE == 2'd3);
      end else if (addr_done) begin
        a_valid <= 1'b0;
      end
      if (addr_done) begin
        HWDATA  <= a_wdata;
        d_write <= HWRITE;
        d_bad   <= a_bad;
      end
      RSP_VALID <= data_done;
      RSP_ERROR <= data_done && (data_err || d_bad);
      RSP_RDATA <= (data_done && !d_write && !data_err) ? HRDATA : 32'h0;
    end
  end

endmodule
